// File: rtl/adc_frame_pkg.sv
// Shared constants and types for the ADC sample framer.
package adc_frame_pkg;

  localparam logic [7:0]  FRAME_HDR = 8'hA5;
  localparam int unsigned SAMPLE_W  = 16;
  localparam int unsigned BYTE_W    = 8;
  // Wide enough to count up to the largest legal frame of 8 samples.
  localparam int unsigned CNT_W     = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    SEQ  = 3'd2,
    LOAD = 3'd3,
    MSB  = 3'd4,
    LSB  = 3'd5,
    CSUM = 3'd6
  } state_e;

  function automatic logic [BYTE_W-1:0] csum_add(input logic [BYTE_W-1:0] acc,
                                                 input logic [BYTE_W-1:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/adc_frame_tx_if.sv
// FIFO show-ahead read port plus byte valid/ready stream used by the framer.
interface adc_frame_tx_if;
  import adc_frame_pkg::*;

  logic [SAMPLE_W-1:0] fifo_q;
  logic                fifo_empty;
  logic                fifo_burst;
  logic                fifo_re;
  logic [BYTE_W-1:0]   tx_data;
  logic                tx_valid;
  logic                tx_ready;

  // master = the framer, slave = FIFO/transmitter side.
  modport master (
    input  fifo_q, fifo_empty, fifo_burst, tx_ready,
    output fifo_re, tx_data, tx_valid
  );

  modport slave (
    output fifo_q, fifo_empty, fifo_burst, tx_ready,
    input  fifo_re, tx_data, tx_valid
  );

endinterface

// File: rtl/adc_frame_tx.sv
// Drains 16-bit samples from the ADC FIFO and emits header/seq/samples/checksum
// byte frames on a valid/ready stream.
module adc_frame_tx
  import adc_frame_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned FRAME_SAMPLES = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  adc_frame_tx_if.master      tx_if,
  output logic                frame_active,
  output logic [BYTE_W-1:0]   frame_count
);

  state_e                  r_state,    w_state_nxt;
  logic [BYTE_W-1:0]       r_tx_data,  w_tx_data_nxt;
  logic                    r_tx_valid, w_tx_valid_nxt;
  logic [BYTE_W-1:0]       r_csum,     w_csum_nxt;
  logic [CNT_W-1:0]        r_cnt,      w_cnt_nxt;
  logic [DATA_WIDTH-1:0]   r_word,     w_word_nxt;
  logic                    r_active,   w_active_nxt;
  logic [BYTE_W-1:0]       r_count,    w_count_nxt;

  logic                    w_xfer;
  logic                    w_pop;
  logic [CNT_W-1:0]        w_cnt_inc;
  logic [BYTE_W-1:0]       w_word_msb;
  logic [BYTE_W-1:0]       w_word_lsb;
  logic [BYTE_W-1:0]       w_csum_lsb;
  logic [DATA_WIDTH-1:0]   w_fifo_word;

  assign w_xfer      = r_tx_valid && tx_if.tx_ready;
  // Reset gates the pop so an aborted frame never consumes a word.
  assign w_pop       = (r_state == LOAD) && !tx_if.fifo_empty && !reset;
  assign w_cnt_inc   = r_cnt + CNT_W'(1);
  assign w_word_msb  = r_word[DATA_WIDTH-1 -: BYTE_W];
  assign w_word_lsb  = r_word[BYTE_W-1:0];
  assign w_csum_lsb  = csum_add(r_csum, w_word_lsb);
  assign w_fifo_word = DATA_WIDTH'(tx_if.fifo_q);

  assign tx_if.fifo_re  = w_pop;
  assign tx_if.tx_data  = r_tx_data;
  assign tx_if.tx_valid = r_tx_valid;
  assign frame_active   = r_active;
  assign frame_count    = r_count;

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_csum     <= '0;
      r_cnt      <= '0;
      r_word     <= '0;
      r_active   <= 1'b0;
      r_count    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_valid <= w_tx_valid_nxt;
      r_csum     <= w_csum_nxt;
      r_cnt      <= w_cnt_nxt;
      r_word     <= w_word_nxt;
      r_active   <= w_active_nxt;
      r_count    <= w_count_nxt;
    end
  end

  // Next-state, byte mux and checksum accumulation.
  always_comb begin
    w_state_nxt    = r_state;
    w_tx_data_nxt  = r_tx_data;
    w_tx_valid_nxt = r_tx_valid;
    w_csum_nxt     = r_csum;
    w_cnt_nxt      = r_cnt;
    w_word_nxt     = r_word;
    w_active_nxt   = r_active;
    w_count_nxt    = r_count;

    case (r_state)
      IDLE: begin
        if (enable && tx_if.fifo_burst) begin
          w_state_nxt    = HDR;
          w_tx_valid_nxt = 1'b1;
          w_tx_data_nxt  = FRAME_HDR;
          w_csum_nxt     = '0;
          w_cnt_nxt      = '0;
          w_active_nxt   = 1'b1;
        end
      end
      HDR: begin
        if (w_xfer) begin
          w_state_nxt   = SEQ;
          w_tx_data_nxt = r_count;
        end
      end
      SEQ: begin
        if (w_xfer) begin
          w_state_nxt    = LOAD;
          w_tx_valid_nxt = 1'b0;
          w_csum_nxt     = csum_add(r_csum, r_count);
        end
      end
      LOAD: begin
        // Stall here with nothing presented while the FIFO is dry.
        if (w_pop) begin
          w_state_nxt    = MSB;
          w_word_nxt     = w_fifo_word;
          w_tx_valid_nxt = 1'b1;
          w_tx_data_nxt  = w_fifo_word[DATA_WIDTH-1 -: BYTE_W];
        end
      end
      MSB: begin
        if (w_xfer) begin
          w_state_nxt   = LSB;
          w_csum_nxt    = csum_add(r_csum, w_word_msb);
          w_tx_data_nxt = w_word_lsb;
        end
      end
      LSB: begin
        if (w_xfer) begin
          w_csum_nxt = w_csum_lsb;
          w_cnt_nxt  = w_cnt_inc;
          if (w_cnt_inc == CNT_W'(FRAME_SAMPLES)) begin
            w_state_nxt   = CSUM;
            w_tx_data_nxt = w_csum_lsb;
          end else begin
            w_state_nxt    = LOAD;
            w_tx_valid_nxt = 1'b0;
          end
        end
      end
      CSUM: begin
        if (w_xfer) begin
          w_state_nxt    = IDLE;
          w_tx_valid_nxt = 1'b0;
          w_active_nxt   = 1'b0;
          w_count_nxt    = r_count + BYTE_W'(1);
        end
      end
      default: begin
        w_state_nxt    = IDLE;
        w_tx_valid_nxt = 1'b0;
        w_active_nxt   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_adc_frame_tx.sv
// Scoreboard bench for adc_frame_tx: FIFO model, byte stream monitor, directed scenarios.
module tb_adc_frame_tx;

  localparam int unsigned NS = 8;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       frame_active;
  logic [7:0] frame_count;

  adc_frame_tx_if tx_if();

  adc_frame_tx #(.DATA_WIDTH(16), .FRAME_SAMPLES(NS)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .tx_if        (tx_if),
    .frame_active (frame_active),
    .frame_count  (frame_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // FIFO model with show-ahead head word
  logic [15:0] mem [0:1023];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          pops   = 0;
  bit          force_empty = 1'b0;
  bit          burst_en    = 1'b1;

  assign tx_if.fifo_q     = mem[rd_ptr[9:0]];
  assign tx_if.fifo_empty = (wr_ptr == rd_ptr) || force_empty;
  assign tx_if.fifo_burst = burst_en && ((wr_ptr - rd_ptr) >= 8);

  always @(posedge clk) begin
    if (tx_if.fifo_re) begin
      rd_ptr <= rd_ptr + 1;
      pops   <= pops + 1;
    end
  end

  bit   rand_ready = 1'b0;
  logic ready_lvl  = 1'b1;

  always @(posedge clk) begin
    #1;
    tx_if.tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_lvl;
  end

  // Scoreboard of expected stream bytes
  logic [7:0]  exp_q [$];
  logic [15:0] frame_w [NS];

  task automatic push_words();
    for (int i = 0; i < int'(NS); i++) begin
      mem[wr_ptr[9:0]] = frame_w[i];
      wr_ptr++;
    end
  endtask

  task automatic push_exp(input logic [7:0] seq);
    logic [7:0] cs;
    exp_q.push_back(8'hA5);
    exp_q.push_back(seq);
    cs = seq;
    for (int i = 0; i < int'(NS); i++) begin
      exp_q.push_back(frame_w[i][15:8]);
      exp_q.push_back(frame_w[i][7:0]);
      cs = cs + frame_w[i][15:8] + frame_w[i][7:0];
    end
    exp_q.push_back(cs);
  endtask

  task automatic add_frame(input logic [7:0] seq);
    push_exp(seq);
    push_words();
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < int'(NS); i++)
      frame_w[i] = 16'h0102 + 16'(i) * 16'h0202;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < int'(NS); i++)
      frame_w[i] = 16'($urandom);
  endtask

  // Output monitor sampled on the falling edge
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  int         act_cnt    = 0;
  int         last_len   = 0;

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
      act_cnt    = 0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(tx_if.tx_valid), 32'(1));
        check("hold_data", 32'(tx_if.tx_data), 32'(prev_data));
      end
      if (tx_if.tx_valid && tx_if.tx_ready) begin
        if (exp_q.size() == 0) check("extra_byte", 32'(tx_if.tx_valid), 32'(0));
        else check("byte", 32'(tx_if.tx_data), 32'(exp_q.pop_front()));
      end
      if (tx_if.fifo_re) begin
        check("re_empty", 32'(tx_if.fifo_empty), 32'(0));
        check("re_valid", 32'(tx_if.tx_valid), 32'(0));
      end
      prev_stall = tx_if.tx_valid && !tx_if.tx_ready;
      prev_data  = tx_if.tx_data;
      if (frame_active) act_cnt++;
      else if (act_cnt != 0) begin
        last_len = act_cnt;
        act_cnt  = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    step();
    while ((exp_q.size() != 0 || frame_active || tx_if.tx_valid) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      check("timeout_pending", 32'(exp_q.size()), 32'(0));
      check("timeout_active", 32'(frame_active), 32'(0));
      check("timeout_valid", 32'(tx_if.tx_valid), 32'(0));
    end
    step();
  endtask

  task automatic wait_pops(input int target, input int budget);
    int n = 0;
    while (pops < target && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) check("wait_pops", 32'(pops), 32'(target));
  endtask

  initial begin
    int base;
    clk    = 1'b0;
    reset  = 1'b1;
    enable = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();
    check("rst_valid", 32'(tx_if.tx_valid), 32'(0));
    check("rst_active", 32'(frame_active), 32'(0));
    check("rst_count", 32'(frame_count), 32'(0));
    check("rst_re", 32'(tx_if.fifo_re), 32'(0));

    // Basic ramp frame, checksum 0x88
    fill_ramp();
    add_frame(8'h00);
    enable = 1'b1;
    wait_done(200);
    check("t1_count", 32'(frame_count), 32'(1));
    check("t1_pops", 32'(pops), 32'(8));
    check("t1_len", 32'(last_len), 32'(27));

    // Back-to-back frames
    fill_rand();
    add_frame(8'h01);
    fill_rand();
    add_frame(8'h02);
    wait_done(400);
    check("t2_count", 32'(frame_count), 32'(3));
    check("t2_pops", 32'(pops), 32'(24));

    // Random backpressure
    rand_ready = 1'b1;
    fill_ramp();
    add_frame(8'h03);
    wait_done(2000);
    rand_ready = 1'b0;
    check("t3_count", 32'(frame_count), 32'(4));
    check("t3_pops", 32'(pops), 32'(32));

    // Underrun at the 4th LOAD
    base = pops;
    fill_rand();
    add_frame(8'h04);
    wait_pops(base + 3, 200);
    force_empty = 1'b1;
    repeat (10) step();
    check("t4_stall_pops", 32'(pops), 32'(base + 3));
    check("t4_stall_valid", 32'(tx_if.tx_valid), 32'(0));
    check("t4_stall_active", 32'(frame_active), 32'(1));
    force_empty = 1'b0;
    wait_done(400);
    check("t4_pops", 32'(pops), 32'(base + 8));
    check("t4_count", 32'(frame_count), 32'(5));

    // enable dropped after the header with a second burst waiting
    base = pops;
    fill_rand();
    add_frame(8'h05);
    fill_rand();
    push_words();
    begin
      int n = 0;
      while (!frame_active && n < 100) begin
        step();
        n++;
      end
      if (n >= 100) check("t5_start", 32'(frame_active), 32'(1));
    end
    step();
    enable = 1'b0;
    wait_done(400);
    repeat (40) step();
    check("t5_no_start", 32'(frame_active), 32'(0));
    check("t5_idle_valid", 32'(tx_if.tx_valid), 32'(0));
    check("t5_pops", 32'(pops), 32'(base + 8));
    check("t5_count", 32'(frame_count), 32'(6));

    // Reset asserted mid-sample
    base = pops;
    push_exp(8'h06);
    enable = 1'b1;
    wait_pops(base + 2, 200);
    reset = 1'b1;
    step();
    check("t5r_valid", 32'(tx_if.tx_valid), 32'(0));
    check("t5r_re", 32'(tx_if.fifo_re), 32'(0));
    check("t5r_count", 32'(frame_count), 32'(0));
    check("t5r_active", 32'(frame_active), 32'(0));
    check("t5r_pops", 32'(pops), 32'(base + 2));
    exp_q.delete();
    wr_ptr = rd_ptr;
    reset  = 1'b0;
    step();

    // Sequence wrap over 257 frames
    for (int f = 0; f < 257; f++) begin
      fill_rand();
      add_frame(8'(f));
      wait_done(400);
      if (f == 255) check("t6_wrap", 32'(frame_count), 32'(0));
    end
    check("t6_final", 32'(frame_count), 32'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_frame_tx.md
Name: adc_frame_tx

Overview:
Reader side of the ADC sample FIFO. It drains 16-bit samples from the FIFO's show-ahead read port and packs them into fixed-length byte frames: header, sequence number, samples sent MSB first, then a checksum. Frames go out on a byte valid/ready stream to the downstream UART/telemetry transmitter. A frame starts only when the FIFO reports a full burst available, and the block stalls safely if the FIFO runs dry mid-frame.

Parameters:
DATA_WIDTH, 16, sample width; fixed at 16 (two bytes per sample).
FRAME_SAMPLES, 8, samples per frame; legal range 1..8, which keeps it at or below the FIFO burst threshold.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
enable  input  1  permits new frames to start
fifo_q  input  16  FIFO head word; valid whenever fifo_empty=0
fifo_empty  input  1  FIFO empty flag
fifo_burst  input  1  FIFO holds at least 8 words
fifo_re  output  1  pop strobe, combinational, one cycle per word
tx_data  output  8  byte to transmitter
tx_valid  output  1  tx_data valid (registered)
tx_ready  input  1  transmitter accepts byte
frame_active  output  1  high from frame start until the checksum byte is accepted
frame_count  output  8  sequence number of the next frame; wraps 0xFF->0x00

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, sequence 0, checksum 0. Reset mid-frame aborts the frame immediately: no further bytes, no pop.
- Frame format: 0xA5, seq, then {s[15:8], s[7:0]} for each of FRAME_SAMPLES samples, then csum.
  - csum = 8-bit modulo-256 sum of seq and all sample bytes.
  - The header is not included in csum.
- Handshake:
  - A byte transfers on a cycle where tx_valid && tx_ready.
  - While tx_valid=1 and tx_ready=0, tx_data and tx_valid hold stable.
  - tx_valid never drops without a transfer, except on reset.
- States: IDLE, HDR, SEQ, LOAD, MSB, LSB, CSUM.
- IDLE:
  - If enable && fifo_burst: next cycle goes to HDR with tx_valid=1, tx_data=0xA5.
  - Clear the checksum and sample counter; frame_active=1.
- HDR: on transfer -> SEQ with tx_data=frame_count on the next cycle.
- SEQ: on transfer -> LOAD, tx_valid=0, csum+=seq.
- LOAD:
  - fifo_re = (state==LOAD) && !fifo_empty.
  - On a pop, capture fifo_q into the word register the same cycle, then -> MSB with tx_valid=1 next cycle.
  - If fifo_empty, stay in LOAD with no pop (stall).
- MSB: on transfer -> LSB next cycle, csum+=word[15:8].
- LSB: on transfer, csum+=word[7:0] and the sample counter increments.
  - Counter reaches FRAME_SAMPLES -> CSUM, presenting csum including this byte next cycle.
  - Otherwise -> LOAD.
- CSUM: on transfer -> IDLE, frame_active=0, frame_count+=1 (wrapping).
- enable deasserted mid-frame: the current frame completes normally, and no new frame starts. enable is sampled only in IDLE.
- fifo_re is never asserted when fifo_empty=1, and never outside LOAD. Exactly FRAME_SAMPLES pops occur per frame.
- Minimum frame duration with tx_ready tied high: 1 (start) + 2 + 3·FRAME_SAMPLES + 1 cycles. That is 28 cycles for 8 samples.
- fifo_burst is ignored after the frame starts.

Decomposition:
- Package adc_frame_pkg holds:
  - FRAME_HDR = 8'hA5
  - the state enum type (IDLE, HDR, SEQ, LOAD, MSB, LSB, CSUM)
  - the sample-count width constant
- A single flat module; no sub-module is warranted. The checksum accumulator and byte mux stay inline.

Test Plan:
1. Basic frame. FIFO holds 0x0102,0x0304,…,0x0F10; burst=1, enable=1, tx_ready=1. Expected bytes: A5 00 01 02 03 … 0F 10 88. Exactly 8 pops, frame_count becomes 0x01.
2. Back-to-back frames. 16 words preloaded. Second frame starts with A5 01. Checksum includes seq=0x01. frame_count becomes 0x02.
3. Backpressure. Toggle tx_ready with a random pattern. tx_data and tx_valid stay stable while ready=0. The byte sequence is identical to scenario 1, and no pop occurs while MSB/LSB is pending.
4. FIFO underrun mid-frame. Force fifo_empty=1 at the 4th LOAD for 10 cycles. The block holds in LOAD with fifo_re=0 and tx_valid=0, then resumes. Frame bytes are correct.
5. Control edges.
   - enable dropped after the header: the frame completes and no new frame starts even with burst=1.
   - reset asserted mid-sample: the next cycle has tx_valid=0 and fifo_re=0, and frame_count=0.
6. Sequence wrap. Run 256 frames. frame_count wraps 0xFF->0x00, and the seq byte of frame 257 is 0x00.
